// File: rtl/ps2_mouse_packet_decoder.sv
// PS/2 mouse receiver in the system clock domain: frame capture,
// packet assembly, paddle speed mapping, timeout resync and error codes.
module ps2_mouse_packet_decoder #(
    parameter int PACKET_BYTES   = 3,
    parameter int SPEED_WIDTH    = 8,
    parameter int AXIS           = 0,
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                   clk_25MHz,
    input  logic                   reset,
    input  logic                   ps2_clk,
    input  logic                   data_in,
    output logic                   paddle_dir,
    output logic [SPEED_WIDTH-1:0] paddle_speed,
    output logic [8:0]             x_delta,
    output logic [8:0]             y_delta,
    output logic [2:0]             buttons,
    output logic [3:0]             wheel,
    output logic                   new_output_flag,
    output logic                   error_flag,
    output logic [2:0]             error_code
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [9:0] SMAX = 10'((1 << SPEED_WIDTH) - 1);
    localparam logic [1:0] LAST = 2'(PACKET_BYTES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   clk_prev_q;
    logic                   ev, din, active;

    state_t          state_q, state_d;
    logic [3:0]      bit_q, bit_d;
    logic [9:0]      sh_q, sh_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][7:0] pkt_q, pkt_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic                   dir_q, dir_d;
    logic [SPEED_WIDTH-1:0] spd_q, spd_d;
    logic [8:0]             x_q, x_d, y_q, y_d;
    logic [2:0]             btn_q, btn_d;
    logic [3:0]             whl_q, whl_d;
    logic                   flag_q, flag_d;
    logic                   errf_q, errf_d;
    logic [2:0]             errc_q, errc_d;

    logic       err, pkt_ok, sel_sign, sel_ovf;
    logic [2:0] ecode;
    logic [7:0] sel_byte;
    logic [9:0] mag;

    assign ev     = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign din    = dat_sync_q[SYNC_STAGES-1];
    assign active = (state_q != IDLE) || (idx_q != 2'd0);

    always_ff @(posedge clk_25MHz) begin
        if (!reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            state_q    <= IDLE;
            bit_q      <= '0;
            sh_q       <= '0;
            idx_q      <= '0;
            pkt_q      <= '0;
            tmo_q      <= '0;
            dir_q      <= 1'b0;
            spd_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            btn_q      <= '0;
            whl_q      <= '0;
            flag_q     <= 1'b0;
            errf_q     <= 1'b0;
            errc_q     <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], data_in};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
            state_q    <= state_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            idx_q      <= idx_d;
            pkt_q      <= pkt_d;
            tmo_q      <= tmo_d;
            dir_q      <= dir_d;
            spd_q      <= spd_d;
            x_q        <= x_d;
            y_q        <= y_d;
            btn_q      <= btn_d;
            whl_q      <= whl_d;
            flag_q     <= flag_d;
            errf_q     <= errf_d;
            errc_q     <= errc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        pkt_d   = pkt_q;
        tmo_d   = tmo_q;
        dir_d   = dir_q;
        spd_d   = spd_q;
        x_d     = x_q;
        y_d     = y_q;
        btn_d   = btn_q;
        whl_d   = whl_q;
        flag_d  = 1'b0;
        errf_d  = errf_q;
        errc_d  = errc_q;
        err     = 1'b0;
        ecode   = 3'd0;
        pkt_ok  = 1'b0;

        if (ev) tmo_d = '0;
        else if (active) tmo_d = tmo_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (ev && !din) begin
                    state_d = SHIFT;
                    bit_d   = 4'd1;
                end else if (ev) begin
                    err   = 1'b1;
                    ecode = 3'd1;
                end
            end
            SHIFT: begin
                if (ev) begin
                    sh_d  = {din, sh_q[9:1]};
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd10) state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (!(^sh_q[8:0])) begin
                    err   = 1'b1;
                    ecode = 3'd2;
                end else if (!sh_q[9]) begin
                    err   = 1'b1;
                    ecode = 3'd3;
                end else if (idx_q == 2'd0 && !sh_q[3]) begin
                    err   = 1'b1;
                    ecode = 3'd4;
                end else begin
                    pkt_d[idx_q] = sh_q[7:0];
                    if (idx_q == LAST) begin
                        idx_d  = 2'd0;
                        pkt_ok = 1'b1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // An edge in the same cycle always rescues the frame
        if (!ev && active && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            err     = 1'b1;
            ecode   = 3'd5;
            state_d = IDLE;
            tmo_d   = '0;
            pkt_ok  = 1'b0;
        end

        if (err) begin
            idx_d  = 2'd0;
            errf_d = 1'b1;
            errc_d = ecode;
        end

        sel_sign = (AXIS != 0) ? pkt_d[0][5] : pkt_d[0][4];
        sel_ovf  = (AXIS != 0) ? pkt_d[0][7] : pkt_d[0][6];
        sel_byte = (AXIS != 0) ? pkt_d[2] : pkt_d[1];
        mag      = sel_sign ? (10'd256 - {2'b00, sel_byte})
                            : {2'b00, sel_byte};

        if (pkt_ok) begin
            x_d    = {pkt_d[0][4], pkt_d[1]};
            y_d    = {pkt_d[0][5], pkt_d[2]};
            btn_d  = pkt_d[0][2:0];
            whl_d  = (PACKET_BYTES == 4) ? pkt_d[3][3:0] : 4'd0;
            dir_d  = sel_sign;
            spd_d  = (sel_ovf || mag > SMAX) ? '1 : mag[SPEED_WIDTH-1:0];
            flag_d = 1'b1;
            errf_d = 1'b0;
            errc_d = 3'd0;
        end
    end

    assign paddle_dir      = dir_q;
    assign paddle_speed    = spd_q;
    assign x_delta         = x_q;
    assign y_delta         = y_q;
    assign buttons         = btn_q;
    assign wheel           = whl_q;
    assign new_output_flag = flag_q;
    assign error_flag      = errf_q;
    assign error_code      = errc_q;
endmodule

// File: doc/ps2_mouse_packet_decoder.md
Name: ps2_mouse_packet_decoder

Overview:
Parametrised PS/2 mouse receiver that runs entirely in the clk_25MHz domain. It oversamples ps2_clk and data_in, assembles 11-bit frames, checks the start, parity and stop bits, and assembles 3-byte (standard) or 4-byte (wheel) packets. It outputs signed X/Y deltas, buttons and wheel, plus a saturated paddle speed and direction for a selectable axis. It replaces the ps2_clk-edge-clocked decoder, adds a timeout-based resync and error codes, and sits between the PS/2 pins and the paddle controller.

Parameters:
PACKET_BYTES, 3, packet length; only 3 or 4 are legal, 4 enables wheel byte decode.
SPEED_WIDTH, 8, width of paddle_speed (1..9).
AXIS, 0, paddle source axis: 0 = X, 1 = Y.
TIMEOUT_CYCLES, 25000, clk_25MHz cycles without a ps2_clk falling edge before a partial frame or packet is aborted (1 ms).
SYNC_STAGES, 2, synchroniser flops on ps2_clk and data_in (>= 2).

Ports:
clk_25MHz  in  1  system clock, the only clock.
reset  in  1  synchronous, active-low reset.
ps2_clk  in  1  asynchronous PS/2 clock from the pin.
data_in  in  1  asynchronous PS/2 data from the pin.
paddle_dir  out  1  sign of the selected axis delta (1 = negative).
paddle_speed  out  SPEED_WIDTH  saturated magnitude of the selected axis.
x_delta  out  9  signed X movement {sign, byte1}.
y_delta  out  9  signed Y movement {sign, byte2}.
buttons  out  3  {middle, right, left} from byte0[2:0].
wheel  out  4  signed byte3[3:0]; held 0 when PACKET_BYTES = 3.
new_output_flag  out  1  one-cycle pulse when a new packet's outputs are valid.
error_flag  out  1  sticky error level.
error_code  out  3  code of the most recent error.

Behaviour:
- Reset is sampled only on clk_25MHz rising edges when reset = 0. All outputs go to 0, the FSM goes to IDLE, byte index and timeout counter go to 0, and synchronisers preset to 1. A reset mid-frame discards all partial data.
- Sampling: ps2_clk and data_in each pass through SYNC_STAGES flops. An edge event is sync'd clock previous = 1 and current = 0. data is sampled from the synchronised data_in on the event cycle.
- Frame FSM:
  - IDLE: on an event with data = 0, go to SHIFT with bit count 1. An event with data = 1 raises error code 1 (bad start) and stays in IDLE.
  - SHIFT: bits 1..8 are data, LSB first; bit 9 is parity; bit 10 is stop. After bit 10, go to CHECK.
  - CHECK: one cycle. Parity must be odd over data+parity, otherwise error code 2. Stop must be 1, otherwise error code 3. Then return to IDLE.
- Packet assembly:
  - A byte that passes CHECK is stored at the current byte index.
  - Byte index 0 requires bit3 = 1. Otherwise error code 4 (misalignment), the byte is dropped, and the index stays at 0.
  - Any frame error forces the byte index to 0 and discards the partial packet.
- Timeout: the counter clears on every event and increments otherwise while FSM != IDLE or byte index != 0. When it reaches TIMEOUT_CYCLES: error code 5, FSM to IDLE, byte index to 0, counter to 0. The counter does not run when fully idle.
- Completion: when the last byte passes CHECK, all data outputs update and new_output_flag = 1 on the cycle after CHECK. Latency is 2 cycles from the stop-bit event; the flag is high for exactly 1 cycle. Outputs hold until the next good packet.
- Packet fields:
  - byte0 = {Yovf, Xovf, Ysign, Xsign, 1, M, R, L}.
  - x_delta = {byte0[4], byte1}; y_delta = {byte0[5], byte2}.
- Speed:
  - mag = |delta| of the selected axis, computed 10 bits wide, so -256 gives 256.
  - If the axis overflow bit is set or mag > 2^SPEED_WIDTH - 1, paddle_speed is all ones; otherwise mag.
  - paddle_dir = sign bit. Direction is kept on overflow.
- Errors: on any error, error_flag = 1 and error_code is updated; the latest error wins. Both are cleared to 0 only on a good packet completion, in the same cycle as new_output_flag. The flag is never pulsed for an errored packet.
- Simultaneous events: a timeout and an event in the same cycle are resolved in favour of the event, so no timeout fires.

Test Plan:
- Good packet (AXIS=0) 0x08, 0x20, 0x05 -> x_delta=32, y_delta=5, speed=32, dir=0, buttons=0, one flag pulse 2 cycles after the 3rd stop edge, error_flag=0.
- Negative X: 0x19, 0xF0, 0x00 -> x_delta=-16, speed=16, dir=1, buttons=3'b001. Then 0x18, 0x00, 0x00 -> speed=256, saturates to 255.
- Overflow: 0x48, 0x10, 0x00 -> speed=255, dir=0. With AXIS=1 and 0x28, 0x00, 0xFB -> speed=5, dir=1.
- Parity error on byte 2 -> error_flag=1, code=2, no flag pulse. The next good packet decodes and clears error_flag/code.
- Send 5 bits then idle 25000 cycles -> code=5, FSM IDLE. The following full packet decodes. Send byte0 = 0x00 -> code=4, index stays at 0.
- PACKET_BYTES=4: 0x08, 0x01, 0x02, 0x0F -> wheel=-1, flag only after the 4th byte. Assert reset mid-byte 2 -> all outputs 0, no pulse.
